// File: rtl/match_event_counter_pkg.sv
// Shared types and defaults for the match-event counter family.
// The optional MATCH_EDGE_ONLY_EN build switch is consumed by the top module.
package match_event_counter_pkg;

  localparam int COMPARE_W = 128;

  localparam logic [COMPARE_W-1:0] DEFAULT_MATCH_PATTERN = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
  localparam logic [COMPARE_W-1:0] DEFAULT_MATCH_MASK    = {COMPARE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    SAT   = 2'd3
  } state_t;

  // Bits with mask=0 are don't-care.
  function automatic logic masked_equal(input logic [COMPARE_W-1:0] data,
                                        input logic [COMPARE_W-1:0] pattern,
                                        input logic [COMPARE_W-1:0] mask);
    return ((data ^ pattern) & mask) == '0;
  endfunction

endpackage

// File: rtl/match_event_pattern_match.sv
// Combinational masked pattern compare: in_data -> hit.
// Kept separate so other monitor variants can reuse it.
module match_event_pattern_match
  import match_event_counter_pkg::*;
#(
  parameter logic [COMPARE_W-1:0] PATTERN = DEFAULT_MATCH_PATTERN,
  parameter logic [COMPARE_W-1:0] MASK    = DEFAULT_MATCH_MASK
) (
  input  logic [COMPARE_W-1:0] data_i,
  output logic                 hit_o
);

  assign hit_o = masked_equal(data_i, PATTERN, MASK);

endmodule

// File: rtl/match_event_counter.sv
// Counts accepted stream beats matching a masked pattern; saturating counter with IDLE/ARMED/COUNT/SAT FSM.
// Build option: define MATCH_EDGE_ONLY_EN to count only the first beat of each run of matching beats.
module match_event_counter
  import match_event_counter_pkg::*;
#(
  parameter logic [COMPARE_W-1:0] MATCH_PATTERN = DEFAULT_MATCH_PATTERN,
  parameter logic [COMPARE_W-1:0] MATCH_MASK    = DEFAULT_MATCH_MASK,
  parameter int                   CNT_W         = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm_i,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic [COMPARE_W-1:0] in_data_i,
  output logic                 in_ready_o,
  output logic [COMPARE_W-1:0] count_o,
  output logic                 active_o,
  output logic                 sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             sat_q, sat_d;
  logic             beat_match;
  logic             accept;
`ifdef MATCH_EDGE_ONLY_EN
  logic             prev_q, prev_d;
`endif

  match_event_pattern_match #(
    .PATTERN (MATCH_PATTERN),
    .MASK    (MATCH_MASK)
  ) u_match (
    .data_i (in_data_i),
    .hit_o  (beat_match)
  );

  // Ready is withheld during reset so upstream never loses a beat to it.
  assign in_ready_o = ((state_q == ARMED) || (state_q == COUNT)) && !rst;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef MATCH_EDGE_ONLY_EN
    prev_d  = prev_q;
`endif
    if (clear_i) begin
      cnt_d   = '0;
      state_d = arm_i ? ARMED : IDLE;
`ifdef MATCH_EDGE_ONLY_EN
      prev_d  = 1'b0;
`endif
    end else if (!arm_i) begin
      state_d = IDLE;
`ifdef MATCH_EDGE_ONLY_EN
      prev_d  = 1'b0;
`endif
    end else begin
      if (accept) begin
`ifdef MATCH_EDGE_ONLY_EN
        hit_d  = beat_match && !prev_q;
        prev_d = beat_match;
`else
        hit_d  = beat_match;
`endif
      end
      if (state_q == IDLE) begin
        state_d = ARMED;
      end else if (hit_q) begin
        // A beat accepted alongside the saturating increment still lands here; hold.
        if (cnt_q == CNT_MAX) begin
          state_d = SAT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_d == CNT_MAX) ? SAT : COUNT;
        end
      end
    end
    active_d = (state_d == COUNT);
    sat_d    = (state_d == SAT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      sat_q    <= 1'b0;
`ifdef MATCH_EDGE_ONLY_EN
      prev_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      sat_q    <= sat_d;
`ifdef MATCH_EDGE_ONLY_EN
      prev_q   <= prev_d;
`endif
    end
  end

  always_comb begin
    count_o            = '0;
    count_o[CNT_W-1:0] = cnt_q;
  end

  assign active_o = active_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_match_event_counter.sv
// Directed table-driven bench for match_event_counter: default, byte-mask and 4-bit-counter instances.
// Expected counts follow the MATCH_EDGE_ONLY_EN build setting.
module tb_match_event_counter;

`ifdef MATCH_EDGE_ONLY_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam logic [127:0] A5 = 128'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         arm;
  logic         clr;
  logic         vld;
  logic [127:0] data;

  logic         rdy_a, act_a, sat_a;
  logic         rdy_m, act_m, sat_m;
  logic         rdy_s, act_s, sat_s;
  logic [127:0] cnt_a, cnt_m, cnt_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  match_event_counter dut_a (
    .clk(clk), .rst(rst), .arm_i(arm), .clear_i(clr), .in_valid_i(vld), .in_data_i(data),
    .in_ready_o(rdy_a), .count_o(cnt_a), .active_o(act_a), .sat_o(sat_a)
  );

  match_event_counter #(.MATCH_MASK(128'hFF)) dut_m (
    .clk(clk), .rst(rst), .arm_i(arm), .clear_i(clr), .in_valid_i(vld), .in_data_i(data),
    .in_ready_o(rdy_m), .count_o(cnt_m), .active_o(act_m), .sat_o(sat_m)
  );

  match_event_counter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .arm_i(arm), .clear_i(clr), .in_valid_i(vld), .in_data_i(data),
    .in_ready_o(rdy_s), .count_o(cnt_s), .active_o(act_s), .sat_o(sat_s)
  );

  typedef struct {
    logic         arm;
    logic         clr;
    logic         vld;
    logic [127:0] data;
    logic [127:0] exp_a;
    logic [127:0] exp_m;
    logic [127:0] exp_s;
    logic         rdy;
    logic         act;
    logic         sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic a, input logic c, input logic v, input logic [127:0] d,
                              input logic [127:0] ea, input logic [127:0] em, input logic [127:0] es,
                              input logic r, input logic ac, input logic s);
    vec_t x;
    x.arm = a; x.clr = c; x.vld = v; x.data = d;
    x.exp_a = ea; x.exp_m = em; x.exp_s = es;
    x.rdy = r; x.act = ac; x.sat = s;
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input logic a, input logic c, input logic v, input logic [127:0] d);
    arm = a; clr = c; vld = v; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] up;
    logic [127:0] e;
    int           t6_def [7];
    int           t6_edg [7];
    logic [7:0]   t6_lo  [5];

    rst = 1'b1; arm = 1'b0; clr = 1'b0; vld = 1'b0; data = '0;

    // Table construction
    vecs.push_back(mk(1, 0, 0, '0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      e = EDGE ? ((k >= 2) ? 128'd1 : 128'd0) : 128'(k - 1);
      vecs.push_back(mk(1, 0, 1, A5, e, e, e, 1, (k >= 2), 0));
    end
    e = EDGE ? 128'd1 : 128'd8;
    vecs.push_back(mk(1, 0, 0, '0, e, e, e, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, '0, e, e, e, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, '0, 0, 0, 0, 1, 0, 0));

    up = {$urandom, $urandom, $urandom, $urandom};
    up[64] = 1'b1;
    vecs.push_back(mk(1, 0, 1, {up[127:8], 8'hA5}, 0, 0, 0, 1, 0, 0));
    up = {$urandom, $urandom, $urandom, $urandom};
    up[64] = 1'b1;
    vecs.push_back(mk(1, 0, 1, {up[127:8], 8'h00}, 0, 1, 0, 1, 0, 0));
    up = {$urandom, $urandom, $urandom, $urandom};
    up[64] = 1'b1;
    vecs.push_back(mk(1, 0, 1, {up[127:8], 8'hA5}, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, '0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, '0, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, '0, 0, 0, 0, 1, 0, 0));

    t6_lo  = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5};
    t6_def = '{0, 1, 2, 3, 3, 4, 4};
    t6_edg = '{0, 1, 1, 1, 1, 2, 2};
    for (int k = 0; k < 7; k++) begin
      e = EDGE ? 128'(t6_edg[k]) : 128'(t6_def[k]);
      vecs.push_back(mk(1, 0, (k < 5), (k < 5) ? {120'd0, t6_lo[k]} : 128'd0,
                        e, e, e, 1, (k >= 1), 0));
    end
    vecs.push_back(mk(1, 1, 0, '0, 0, 0, 0, 1, 0, 0));

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_count", cnt_a, 0);
    check("reset_ready", rdy_a, 0);
    check("reset_active", act_a, 0);
    check("reset_sat", sat_a, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].arm, vecs[i].clr, vecs[i].vld, vecs[i].data);
      $display("[TB] row %0d arm=%0b clr=%0b vld=%0b data=%0h -> cnt_a=%0h cnt_m=%0h cnt_s=%0h rdy=%0b act=%0b sat=%0b",
               i, vecs[i].arm, vecs[i].clr, vecs[i].vld, vecs[i].data, cnt_a, cnt_m, cnt_s, rdy_a, act_a, sat_a);
      check($sformatf("row%0d_count_a", i), cnt_a, vecs[i].exp_a);
      check($sformatf("row%0d_count_m", i), cnt_m, vecs[i].exp_m);
      check($sformatf("row%0d_count_s", i), cnt_s, vecs[i].exp_s);
      check($sformatf("row%0d_ready", i), rdy_a, vecs[i].rdy);
      check($sformatf("row%0d_active", i), act_a, vecs[i].act);
      check($sformatf("row%0d_sat", i), sat_a, vecs[i].sat);
    end

    // Saturation of the 4-bit instance: alternating beats give 20 hits in either build
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 1, (i % 2 == 0) ? A5 : 128'd0);
      check("sat_bound", (cnt_s > 128'd15), 0);
    end
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    $display("[TB] saturate cnt_s=%0h sat=%0b rdy=%0b", cnt_s, sat_s, rdy_s);
    check("sat_count", cnt_s, 15);
    check("sat_flag", sat_s, 1);
    check("sat_ready", rdy_s, 0);
    check("sat_active", act_s, 0);
    step(1, 1, 0, '0);
    $display("[TB] clear after sat cnt_s=%0h sat=%0b rdy=%0b", cnt_s, sat_s, rdy_s);
    check("sat_clear_count", cnt_s, 0);
    check("sat_clear_flag", sat_s, 0);
    check("sat_clear_ready", rdy_s, 1);

    // Clear coinciding with an in-flight hit at count 5
    for (int i = 0; i < 11; i++) step(1, 0, 1, (i % 2 == 0) ? A5 : 128'd0);
    $display("[TB] pre-clear cnt_a=%0h", cnt_a);
    check("preclear_count", cnt_a, 5);
    step(1, 1, 0, '0);
    check("clear_hit_count", cnt_a, 0);
    step(1, 0, 0, '0);
    $display("[TB] post-clear cnt_a=%0h", cnt_a);
    check("clear_hit_dropped", cnt_a, 0);

    // Disarm with an in-flight hit at count 3
    for (int i = 0; i < 7; i++) step(1, 0, 1, (i % 2 == 0) ? A5 : 128'd0);
    check("predisarm_count", cnt_a, 3);
    step(0, 0, 1, A5);
    $display("[TB] disarm cnt_a=%0h rdy=%0b act=%0b", cnt_a, rdy_a, act_a);
    check("disarm_count", cnt_a, 3);
    check("disarm_ready", rdy_a, 0);
    check("disarm_active", act_a, 0);
    step(0, 0, 0, '0);
    check("disarm_hold", cnt_a, 3);
    step(1, 0, 0, '0);
    check("rearm_ready", rdy_a, 1);
    check("rearm_count", cnt_a, 3);

    // Reset in the middle of a stream
    step(1, 0, 1, A5);
    step(1, 0, 1, A5);
    rst = 1'b1;
    step(1, 0, 1, A5);
    $display("[TB] midstream reset cnt_a=%0h rdy=%0b", cnt_a, rdy_a);
    check("mrst_count", cnt_a, 0);
    check("mrst_active", act_a, 0);
    check("mrst_sat", sat_a, 0);
    rst = 1'b0;
    step(1, 0, 1, A5);
    check("mrst_idle_count", cnt_a, 0);
    step(1, 0, 0, '0);
    check("mrst_flushed", cnt_a, 0);
    check("mrst_ready", rdy_a, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
